// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, ring-counter T-state bit indices and the control word layout.
package cpu_defs;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_LDI = 4'h4,
    OP_JMP = 4'h5,
    OP_JC  = 4'h6,
    OP_JZ  = 4'h7,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam int unsigned T1 = 0;
  localparam int unsigned T2 = 1;
  localparam int unsigned T3 = 2;
  localparam int unsigned T4 = 3;
  localparam int unsigned T5 = 4;
  localparam int unsigned T6 = 5;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic pc_ld;
    logic mar_ld;
    logic ram_rd;
    logic ram_wr;
    logic ir_ld;
    logic ir_out;
    logic a_ld;
    logic a_out;
    logic b_ld;
    logic alu_sub;
    logic alu_out;
    logic out_ld;
    logic flags_ld;
  } ctrl_word_t;

  function automatic logic is_onehot(input logic [5:0] s);
    return (s != '0) && ((s & (s - 6'd1)) == '0);
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Pure microcode decode: T-state, opcode and flags to raw control word (no gating).
module control_decoder
  import cpu_defs::*;
(
  input  logic [5:0] state_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_flag_i,
  input  logic       carry_flag_i,
  output ctrl_word_t cw_o,
  output logic       halt_req_o
);

  always_comb begin
    cw_o       = '0;
    halt_req_o = 1'b0;

    if (state_i[T1]) begin
      cw_o.pc_out = 1'b1;
      cw_o.mar_ld = 1'b1;
    end
    if (state_i[T2]) cw_o.pc_inc = 1'b1;
    if (state_i[T3]) begin
      cw_o.ram_rd = 1'b1;
      cw_o.ir_ld  = 1'b1;
    end

    if (state_i[T4]) begin
      case (opcode_i)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
          cw_o.ir_out = 1'b1;
          cw_o.mar_ld = 1'b1;
        end
        OP_LDI: begin
          cw_o.ir_out = 1'b1;
          cw_o.a_ld   = 1'b1;
        end
        OP_JMP: begin
          cw_o.ir_out = 1'b1;
          cw_o.pc_ld  = 1'b1;
        end
        OP_JC: begin
          cw_o.ir_out = carry_flag_i;
          cw_o.pc_ld  = carry_flag_i;
        end
        OP_JZ: begin
          cw_o.ir_out = zero_flag_i;
          cw_o.pc_ld  = zero_flag_i;
        end
        OP_OUT: begin
          cw_o.a_out  = 1'b1;
          cw_o.out_ld = 1'b1;
        end
        OP_HLT:  halt_req_o = 1'b1;
        default: ;
      endcase
    end

    if (state_i[T5]) begin
      case (opcode_i)
        OP_LDA: begin
          cw_o.ram_rd = 1'b1;
          cw_o.a_ld   = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          cw_o.ram_rd = 1'b1;
          cw_o.b_ld   = 1'b1;
        end
        OP_STA: begin
          cw_o.a_out  = 1'b1;
          cw_o.ram_wr = 1'b1;
        end
        default: ;
      endcase
    end

    if (state_i[T6] && (opcode_i == OP_ADD || opcode_i == OP_SUB)) begin
      cw_o.alu_out  = 1'b1;
      cw_o.a_ld     = 1'b1;
      cw_o.flags_ld = 1'b1;
      cw_o.alu_sub  = (opcode_i == OP_SUB);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Control unit: owns flags, halt/error latches and retired-instruction count; gates the decoded control word.
module control_unit
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [5:0] state,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_ld,
  output logic       mar_ld,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic       ir_ld,
  output logic       ir_out,
  output logic       a_ld,
  output logic       a_out,
  output logic       b_ld,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_ld,
  output logic       flags_ld,
  output logic       halt,
  output logic       state_err,
  output logic       zero_flag,
  output logic       carry_flag,
  output logic [7:0] instr_cnt
);

  ctrl_word_t cw_raw, cw;
  logic       halt_req, valid, blocked;
  logic       zero_q, zero_d, carry_q, carry_d, halt_q, halt_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  control_decoder u_decoder (
    .state_i      (state),
    .opcode_i     (opcode),
    .zero_flag_i  (zero_q),
    .carry_flag_i (carry_q),
    .cw_o         (cw_raw),
    .halt_req_o   (halt_req)
  );

  // An invalid state blocks the word in the same cycle, before err_q has latched it.
  always_comb begin
    valid   = is_onehot(state);
    blocked = halt_q | err_q | ~valid;
    cw      = blocked ? '0 : cw_raw;
    halt    = halt_q | (halt_req & valid & ~err_q);

    zero_d  = zero_q;
    carry_d = carry_q;
    if (cw.flags_ld) begin
      zero_d  = alu_zero;
      carry_d = alu_carry;
    end
    halt_d = halt;
    err_d  = err_q | ~valid;
    cnt_d  = cnt_q;
    if (state[T6] && !blocked) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_inc     = cw.pc_inc;
  assign pc_out     = cw.pc_out;
  assign pc_ld      = cw.pc_ld;
  assign mar_ld     = cw.mar_ld;
  assign ram_rd     = cw.ram_rd;
  assign ram_wr     = cw.ram_wr;
  assign ir_ld      = cw.ir_ld;
  assign ir_out     = cw.ir_out;
  assign a_ld       = cw.a_ld;
  assign a_out      = cw.a_out;
  assign b_ld       = cw.b_ld;
  assign alu_sub    = cw.alu_sub;
  assign alu_out    = cw.alu_out;
  assign out_ld     = cw.out_ld;
  assign flags_ld   = cw.flags_ld;
  assign state_err  = err_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver pushes model expectations, monitor pops and compares each cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [5:0] state = 6'b000001;
  logic [3:0] opcode = 4'h0;
  logic       alu_zero = 1'b0, alu_carry = 1'b0;
  logic       pc_inc, pc_out, pc_ld, mar_ld, ram_rd, ram_wr, ir_ld, ir_out;
  logic       a_ld, a_out, b_ld, alu_sub, alu_out, out_ld, flags_ld;
  logic       halt, state_err, zero_flag, carry_flag;
  logic [7:0] instr_cnt;

  control_unit dut (
    .clk(clk), .clr_n(clr_n), .state(state), .opcode(opcode),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .pc_inc(pc_inc), .pc_out(pc_out), .pc_ld(pc_ld), .mar_ld(mar_ld),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ir_ld(ir_ld), .ir_out(ir_out),
    .a_ld(a_ld), .a_out(a_out), .b_ld(b_ld), .alu_sub(alu_sub),
    .alu_out(alu_out), .out_ld(out_ld), .flags_ld(flags_ld),
    .halt(halt), .state_err(state_err), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .instr_cnt(instr_cnt)
  );

  always #10 clk = ~clk;

  localparam int B_PC_INC = 14, B_PC_OUT = 13, B_PC_LD = 12, B_MAR_LD = 11, B_RAM_RD = 10;
  localparam int B_RAM_WR = 9, B_IR_LD = 8, B_IR_OUT = 7, B_A_LD = 6, B_A_OUT = 5;
  localparam int B_B_LD = 4, B_ALU_SUB = 3, B_ALU_OUT = 2, B_OUT_LD = 1, B_FLAGS_LD = 0;

  typedef struct {
    logic [14:0] cw;
    logic        halt, err, zf, cf;
    logic [7:0]  cnt;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0, fails = 0, step_id = 0;

  // Behavioural reference state
  bit m_zf, m_cf, m_halt, m_err;
  int m_cnt;

  function automatic int tstate_of(input logic [5:0] s);
    int n = 0, pos = 0;
    for (int i = 0; i < 6; i++) if (s[i]) begin n++; pos = i + 1; end
    return (n == 1) ? pos : 0;
  endfunction

  function automatic logic [14:0] bits(input int a, input int b, input int c = -1);
    logic [14:0] w = '0;
    w[a] = 1'b1; w[b] = 1'b1;
    if (c >= 0) w[c] = 1'b1;
    return w;
  endfunction

  // Expected control word from the instruction table and current model state.
  function automatic logic [14:0] exp_cw(input int t, input int op);
    if (m_halt || m_err || t == 0) return '0;
    case (t)
      1: return bits(B_PC_OUT, B_MAR_LD);
      2: return bits(B_PC_INC, B_PC_INC);
      3: return bits(B_RAM_RD, B_IR_LD);
      4: case (op)
           0, 1, 2, 3: return bits(B_IR_OUT, B_MAR_LD);
           4:  return bits(B_IR_OUT, B_A_LD);
           5:  return bits(B_IR_OUT, B_PC_LD);
           6:  return m_cf ? bits(B_IR_OUT, B_PC_LD) : 15'd0;
           7:  return m_zf ? bits(B_IR_OUT, B_PC_LD) : 15'd0;
           14: return bits(B_A_OUT, B_OUT_LD);
           default: return '0;
         endcase
      5: case (op)
           0:    return bits(B_RAM_RD, B_A_LD);
           1, 2: return bits(B_RAM_RD, B_B_LD);
           3:    return bits(B_A_OUT, B_RAM_WR);
           default: return '0;
         endcase
      default:
        if (op == 1) return bits(B_ALU_OUT, B_A_LD, B_FLAGS_LD);
        else if (op == 2) return bits(B_ALU_OUT, B_A_LD, B_FLAGS_LD) | bits(B_ALU_SUB, B_ALU_SUB);
        else return '0;
    endcase
  endfunction

  function automatic bit exp_halt(input int t, input int op);
    return m_halt || (t == 4 && op == 15 && !m_err);
  endfunction

  task automatic m_reset();
    m_zf = 0; m_cf = 0; m_halt = 0; m_err = 0; m_cnt = 0;
  endtask

  // ract: 0 none, 1 assert clr_n mid-cycle, 2 release clr_n mid-cycle
  task automatic step(input logic [5:0] st, input logic [3:0] op, input bit az, input bit ac,
                      input int ract = 0);
    exp_t e;
    int t;
    logic [14:0] w;
    bit h;
    @(negedge clk);
    state = st; opcode = op; alu_zero = az; alu_carry = ac;
    t = tstate_of(st);
    w = exp_cw(t, int'(op));
    h = exp_halt(t, int'(op));
    e.cw = w; e.halt = h; e.err = m_err; e.zf = m_zf; e.cf = m_cf;
    e.cnt = 8'(m_cnt); e.id = step_id++;
    exp_q.push_back(e);
    if (ract == 1) begin #6; clr_n = 1'b0; m_reset(); end
    else if (ract == 2) begin #6; clr_n = 1'b1; end
    @(posedge clk);
    if (clr_n) begin
      if (w[B_FLAGS_LD]) begin m_zf = az; m_cf = ac; end
      if (t == 6 && !m_halt && !m_err) m_cnt = (m_cnt + 1) % 256;
      if (h) m_halt = 1;
      if (t == 0) m_err = 1;
    end
  endtask

  task automatic instr(input logic [3:0] op, input bit az = 0, input bit ac = 0);
    for (int k = 0; k < 6; k++) step(6'b000001 << k, op, az, ac);
  endtask

  task automatic reset_pulse();
    step(6'b000001, 4'h0, 0, 0, 1);
    step(6'b000001, 4'h0, 0, 0, 0);
    step(6'b000001, 4'h0, 0, 0, 2);
  endtask

  // Monitor: sample away from posedge, pop one expectation per driven cycle.
  initial begin
    exp_t e;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {pc_inc, pc_out, pc_ld, mar_ld, ram_rd, ram_wr, ir_ld, ir_out,
               a_ld, a_out, b_ld, alu_sub, alu_out, out_ld, flags_ld};
        tests++;
        if (act !== e.cw) begin
          fails++;
          $display("FAIL ctrl_word step %0d: got %015b want %015b", e.id, act, e.cw);
        end
        tests++;
        if ({halt, state_err, zero_flag, carry_flag, instr_cnt} !== {e.halt, e.err, e.zf, e.cf, e.cnt}) begin
          fails++;
          $display("FAIL status step %0d: got halt=%b err=%b zf=%b cf=%b cnt=%0d want halt=%b err=%b zf=%b cf=%b cnt=%0d",
                   e.id, halt, state_err, zero_flag, carry_flag, instr_cnt,
                   e.halt, e.err, e.zf, e.cf, e.cnt);
        end
        tests++;
        if ((32'(pc_out) + 32'(ram_rd) + 32'(ir_out) + 32'(a_out) + 32'(alu_out)) > 1) begin
          fails++;
          $display("FAIL bus_drivers step %0d: got %b%b%b%b%b want at most one", e.id,
                   pc_out, ram_rd, ir_out, a_out, alu_out);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    // Reset state while clr_n is held low, then release
    step(6'b000001, 4'h0, 0, 0);
    step(6'b000001, 4'h0, 0, 0, 2);

    instr(4'h0);                      // LDA fetch/execute, count -> 1
    instr(4'h1, 1, 1);                // ADD loads zero/carry
    instr(4'h7);                      // JZ taken
    instr(4'h2, 0, 0);                // SUB clears flags
    instr(4'h6);                      // JC not taken
    instr(4'h1, 0, 1);
    instr(4'h6);                      // JC taken
    instr(4'h3); instr(4'h4); instr(4'h5); instr(4'hE); instr(4'h7);

    for (int i = 0; i < 400; i++)
      instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom));

    // Halt freezes everything until reset
    instr(4'hF);
    instr(4'h0); instr(4'h1, 1, 1); instr(4'h5);
    reset_pulse();
    instr(4'h4);

    // Illegal state patterns are sticky
    step(6'b000011, 4'h0, 0, 0);
    instr(4'h0); instr(4'h1, 1, 1);
    reset_pulse();
    step(6'b000000, 4'h1, 1, 1);
    instr(4'hE);
    reset_pulse();

    // Counter wrap over 256 NOPs
    for (int i = 0; i < 256; i++) instr(4'($urandom_range(8, 13)));
    instr(4'h0);

    // Reset in the middle of ADD leaves no partial update
    reset_pulse();
    for (int k = 0; k < 4; k++) step(6'b000001 << k, 4'h1, 1, 1);
    step(6'b010000, 4'h1, 1, 1, 1);
    step(6'b100000, 4'h1, 1, 1);
    step(6'b000001, 4'h0, 0, 0, 2);
    for (int k = 1; k < 6; k++) step(6'b000001 << k, 4'h8, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all internal registers update on posedge clk.
REQ-002 SHALL have port clr_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port state, input, 6, one-hot T-state from the ring counter: bit0=T1 through bit5=T6; it changes on negedge clk.
REQ-004 SHALL have port opcode, input, 4, instruction-register upper nibble.
REQ-005 SHALL have ports alu_zero and alu_carry, input, 1 each, live ALU status.
REQ-006 SHALL have outputs pc_inc, pc_out, pc_ld, mar_ld, ram_rd, ram_wr, ir_ld, ir_out, a_ld, a_out, b_ld, alu_sub, alu_out, out_ld, flags_ld, each 1 bit; these are the control word.
REQ-007 SHALL have outputs halt, state_err, 1 each; zero_flag, carry_flag, 1 each; instr_cnt, 8, retired-instruction count.

Function
REQ-008 SHALL decode the control word combinationally from state, opcode, flags, halt latch and error latch, so that it is valid before the next posedge after each negedge state change.
REQ-009 SHALL drive fetch regardless of opcode: T1 pc_out+mar_ld; T2 pc_inc; T3 ram_rd+ir_ld.
REQ-010 SHALL decode opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI, 5 JMP, 6 JC, 7 JZ, E OUT, F HLT; 8-D are NOP (no execute signals).
REQ-011 SHALL drive LDA as: T4 ir_out+mar_ld; T5 ram_rd+a_ld; T6 none.
REQ-012 SHALL drive ADD as: T4 ir_out+mar_ld; T5 ram_rd+b_ld; T6 alu_out+a_ld+flags_ld. SUB SHALL be identical to ADD, with alu_sub added in T6.
REQ-013 SHALL drive STA as: T4 ir_out+mar_ld; T5 a_out+ram_wr.
REQ-014 SHALL drive the following in T4: LDI ir_out+a_ld; JMP ir_out+pc_ld; OUT a_out+out_ld.
REQ-015 SHALL drive JC in T4 as ir_out+pc_ld only when carry_flag=1, and JZ likewise only when zero_flag=1; otherwise no signals.
REQ-016 SHALL load zero_flag<=alu_zero and carry_flag<=alu_carry on a posedge where flags_ld=1, and otherwise hold them.
REQ-017 SHALL assert halt combinationally during T4 of HLT and set the halt latch on that posedge; halt SHALL then stay 1 until clr_n.
REQ-018 SHALL force every control-word output to 0 while the halt latch is set.
REQ-019 SHALL increment instr_cnt by 1 on each posedge in T6 when not halted and not in error; the count SHALL wrap from 255 to 0.
REQ-020 SHALL treat a state input that is not one-hot (zero bits or two or more bits set) as an error: the control word SHALL be all 0 that cycle and state_err SHALL be set at the posedge. state_err SHALL be sticky until clr_n and, while set, SHALL hold the control word at 0.
REQ-021 SHALL never assert two bus drivers (pc_out, ram_rd, ir_out, a_out, alu_out) in the same cycle.

Reset
REQ-022 SHALL, while clr_n=0, clear zero_flag, carry_flag, the halt latch, state_err and instr_cnt to 0 immediately, independent of clk.
REQ-023 SHALL, after reset, derive the control word purely from state, so that T1 yields pc_out=mar_ld=1 and all other bits 0.
REQ-024 SHALL abandon an instruction on reset mid-operation, and SHALL not produce a partial flags or count update after clr_n deasserts.

Structure
REQ-025 SHALL take opcode constants and T-state bit indices from a shared definitions file (cpu_defs), which the ring counter and the datapath also use.
REQ-026 SHALL place the pure microcode decode (state, opcode, flags -> control word) in a combinational sub-module control_decoder. control_unit SHALL own the flags, halt, error and count registers and the output gating.

Verification
REQ-027 SHALL cover this scenario: after reset, step state T1..T6 with opcode=0 -> pc_out+mar_ld, pc_inc, ram_rd+ir_ld, ir_out+mar_ld, ram_rd+a_ld, none; instr_cnt=1.
REQ-028 SHALL cover this scenario: ADD with alu_zero=1 and alu_carry=1 at T6 -> flags_ld=1 in T6, zero_flag=carry_flag=1 after the posedge; a following JZ gives pc_ld=1 in T4.
REQ-029 SHALL cover this scenario: JC with carry_flag=0 -> T4 control word all 0; JC with carry_flag=1 -> ir_out+pc_ld=1.
REQ-030 SHALL cover this scenario: HLT -> halt=1 in T4; in later cycles every control bit is 0 and instr_cnt is frozen, until clr_n pulses low, after which halt=0.
REQ-031 SHALL cover this scenario: state=6'b000011 -> control word 0 and state_err=1 after the posedge; state_err stays 1 with valid states afterwards until clr_n.
REQ-032 SHALL cover this scenario: 256 NOP instructions -> instr_cnt wraps to 0; clr_n asserted mid-T5 of ADD -> flags remain 0 and instr_cnt=0.
